fetch_control_unit: RTL and testbench



---
 rtl/slc3_ctrl_pkg.sv | 59 +++++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/fetch_control_unit.sv | 86 ++++++++
 tb/tb_fetch_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/slc3_ctrl_pkg.sv
// Shared definitions for the SLC-3 fetch sequencer: state encoding, PC mux
// selects and the control-word bundle with its per-state decode.
package slc3_ctrl_pkg;

  typedef enum logic [2:0] {
    HALTED = 3'd0,
    S18    = 3'd1,
    S33    = 3'd2,
    S35    = 3'd3,
    PAUSE1 = 3'd4,
    PAUSE2 = 3'd5
  } state_t;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;
  localparam logic [1:0] PCMUX_ZERO = 2'b11;

  typedef struct packed {
    logic       gate_pc;
    logic       gate_marmux;
    logic       gate_mdr;
    logic       gate_alu;
    logic       ld_pc;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic [1:0] pcmux;
    logic       mem_oe;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Control word for a state; last_wait marks the final cycle of the memory
  // wait, where MDR captures the read data.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic last_wait);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      S18: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
        c.pcmux   = PCMUX_INC;
      end
      S33: begin
        c.mem_oe = 1'b1;
        c.ld_mdr = last_wait;
      end
      S35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait timer: cleared to 0, counts up while enabled, and flags done on
// the final wait cycle (count = MEM_WAIT-1). Also exposes next-cycle done.
module mem_wait_timer #(
  parameter int MEM_WAIT = 3
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic done,
  output logic done_next
);

  localparam logic [3:0] LAST = 4'(MEM_WAIT - 1);

  logic [3:0] count_reg;
  logic [3:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = 4'd0;
    end else if (en && !done) begin
      count_next = count_reg + 4'd1;
    end
  end

  assign done      = (count_reg == LAST);
  assign done_next = (count_next == LAST);

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= 4'd0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/fetch_control_unit.sv
// SLC-3 fetch sequencer: MAR<-PC, PC<-PC+1, MDR<-M[MAR], IR<-MDR, then waits
// for a Continue press/release before the next fetch.
module fetch_control_unit
  import slc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Continue,
  output logic             GatePC,
  output logic             GateMARMUX,
  output logic             GateMDR,
  output logic             GateALU,
  output logic             LD_PC,
  output logic             LD_MAR,
  output logic             LD_MDR,
  output logic             LD_IR,
  output logic [1:0]       PCMUX,
  output logic             Mem_OE,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] fetch_count
);

  state_t           state_reg;
  state_t           state_next;
  ctrl_t            ctrl_reg;
  logic [CNT_W-1:0] fetch_count_reg;
  logic             wait_done;
  logic             wait_done_next;

  mem_wait_timer #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk       (CLK),
    .srst      (Reset),
    .clr       (state_reg == S18),
    .en        (state_reg == S33),
    .done      (wait_done),
    .done_next (wait_done_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      HALTED: if (Run) state_next = S18;
      S18:    state_next = S33;
      S33:    if (wait_done) state_next = S35;
      S35:    state_next = PAUSE1;
      PAUSE1: if (Continue) state_next = PAUSE2;
      PAUSE2: if (!Continue) state_next = S18;
      default: state_next = HALTED;
    endcase
  end

  // Controls are registered from the next state so they line up with state_reg.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg       <= HALTED;
      ctrl_reg        <= CTRL_IDLE;
      fetch_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= decode_ctrl(state_next, wait_done_next);
      if (state_reg == S35) begin
        fetch_count_reg <= fetch_count_reg + CNT_W'(1);
      end
    end
  end

  assign GatePC      = ctrl_reg.gate_pc;
  assign GateMARMUX  = ctrl_reg.gate_marmux;
  assign GateMDR     = ctrl_reg.gate_mdr;
  assign GateALU     = ctrl_reg.gate_alu;
  assign LD_PC       = ctrl_reg.ld_pc;
  assign LD_MAR      = ctrl_reg.ld_mar;
  assign LD_MDR      = ctrl_reg.ld_mdr;
  assign LD_IR       = ctrl_reg.ld_ir;
  assign PCMUX       = ctrl_reg.pcmux;
  assign Mem_OE      = ctrl_reg.mem_oe;
  assign state_o     = state_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: two instances (MEM_WAIT=3/CNT_W=16 and
// MEM_WAIT=1/CNT_W=2) checked each cycle against a fetch-phase model.
module tb_fetch_control_unit;

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic Continue = 1'b0;
  int tests = 0;
  int fails = 0;
  bit model_on = 1'b0;

  logic [2:0]  st  [2];
  logic [10:0] ctl [2];  // {GatePC,GateMARMUX,GateMDR,GateALU,LD_PC,LD_MAR,LD_MDR,LD_IR,PCMUX,Mem_OE}
  logic [15:0] fc  [2];

  always #5 CLK = ~CLK;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int MW = (gi == 0) ? 3 : 1;
    localparam int CW = (gi == 0) ? 16 : 2;

    logic gpc, gmm, gmdr, galu, lpc, lmar, lmdr, lir, oe;
    logic [1:0]    pcm;
    logic [2:0]    s;
    logic [CW-1:0] f;

    fetch_control_unit #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
      .CLK(CLK), .Reset(Reset), .Run(Run), .Continue(Continue),
      .GatePC(gpc), .GateMARMUX(gmm), .GateMDR(gmdr), .GateALU(galu),
      .LD_PC(lpc), .LD_MAR(lmar), .LD_MDR(lmdr), .LD_IR(lir),
      .PCMUX(pcm), .Mem_OE(oe), .state_o(s), .fetch_count(f)
    );

    assign st[gi]  = s;
    assign ctl[gi] = {gpc, gmm, gmdr, galu, lpc, lmar, lmdr, lir, pcm, oe};
    assign fc[gi]  = 16'(f);

    // Model: mode 0 halted, 1 fetching, 2 waiting for press, 3 waiting for
    // release. phase counts cycles into a fetch: 0 address, 1..MW memory, MW+1 IR.
    int mode = 0;
    int phase = 0;
    int mcount = 0;

    always @(posedge CLK) begin
      if (Reset) begin
        mode = 0; phase = 0; mcount = 0;
      end else begin
        case (mode)
          0: if (Run) begin mode = 1; phase = 0; end
          1: if (phase == MW + 1) begin
               mode = 2;
               mcount = (mcount + 1) % (1 << CW);
             end else begin
               phase = phase + 1;
             end
          2: if (Continue) mode = 3;
          default: if (!Continue) begin mode = 1; phase = 0; end
        endcase
      end
    end

    always @(negedge CLK) begin
      logic [2:0]  es;
      logic [10:0] ec;
      if (model_on) begin
        es = 3'd0;
        ec = 11'b0;
        case (mode)
          0: es = 3'd0;
          2: es = 3'd4;
          3: es = 3'd5;
          default: begin
            if (phase == 0) begin
              es = 3'd1; ec = 11'b10001100000;
            end else if (phase <= MW) begin
              es = 3'd2;
              ec = (phase == MW) ? 11'b00000010001 : 11'b00000000001;
            end else begin
              es = 3'd3; ec = 11'b00100001000;
            end
          end
        endcase
        tests++;
        if (st[gi] !== es || ctl[gi] !== ec || fc[gi] !== 16'(mcount)) begin
          fails++;
          $display("FAIL model[%0d] t=%0t got state=%0d ctl=%b count=%0d required state=%0d ctl=%b count=%0d",
                   gi, $time, st[gi], ctl[gi], fc[gi], es, ec, mcount);
        end
        tests++;
        if ($countones(ctl[gi][10:7]) > 1 || ctl[gi][9] !== 1'b0 || ctl[gi][7] !== 1'b0 ||
            (ctl[gi][6] && ctl[gi][2:1] !== 2'b00)) begin
          fails++;
          $display("FAIL invariant[%0d] t=%0t got ctl=%b required single gate, no MARMUX/ALU, PCMUX=00 with LD_PC",
                   gi, $time, ctl[gi]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, got);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  seq_st  [6];
    logic [10:0] seq_ctl [6];
    logic [15:0] seq_fc  [6];
    int visits;
    bit found;

    Reset = 1'b1;
    @(negedge CLK);
    model_on = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("idle state", 16'(st[0]), 16'h0);
      check("idle controls", 16'(ctl[0]), 16'h0);
      check("idle count", fc[0], 16'h0);
    end

    // One Run pulse: expected states 1,2,2,2,3,4 for MEM_WAIT=3.
    Run = 1'b1;
    @(negedge CLK);
    Run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge CLK);
      seq_st[k] = st[0]; seq_ctl[k] = ctl[0]; seq_fc[k] = fc[0];
    end
    check("seq state0 S18", 16'(seq_st[0]), 16'd1);
    check("seq state1 S33", 16'(seq_st[1]), 16'd2);
    check("seq state2 S33", 16'(seq_st[2]), 16'd2);
    check("seq state3 S33", 16'(seq_st[3]), 16'd2);
    check("seq state4 S35", 16'(seq_st[4]), 16'd3);
    check("seq state5 PAUSE1", 16'(seq_st[5]), 16'd4);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("LD_MDR cycle%0d", k), 16'(seq_ctl[k][4]), (k == 3) ? 16'd1 : 16'd0);
      check($sformatf("LD_IR cycle%0d", k), 16'(seq_ctl[k][3]), (k == 4) ? 16'd1 : 16'd0);
    end
    check("count before IR", seq_fc[4], 16'd0);
    check("count after fetch", seq_fc[5], 16'd1);

    // Continue held for 20 cycles yields exactly one more fetch.
    Continue = 1'b1;
    repeat (20) @(negedge CLK);
    check("held continue state", 16'(st[0]), 16'd5);
    check("held continue count", fc[0], 16'd1);
    check("held continue state mw1", 16'(st[1]), 16'd5);
    Continue = 1'b0;
    visits = 0;
    repeat (20) begin
      @(negedge CLK);
      if (st[0] == 3'd1) visits++;
    end
    check("S18 visits after release", 16'(visits), 16'd1);
    check("count after release", fc[0], 16'd2);
    check("count after release mw1", fc[1], 16'd2);
    check("back in PAUSE1", 16'(st[0]), 16'd4);

    // Two more single-press fetches; the 2-bit counter wraps 3 -> 0.
    repeat (2) begin
      Continue = 1'b1;
      @(negedge CLK);
      Continue = 1'b0;
      repeat (10) @(negedge CLK);
    end
    check("count 4 fetches", fc[0], 16'd4);
    check("2-bit count wrapped", fc[1], 16'd0);

    // Reset during the second S33 cycle.
    Continue = 1'b1;
    @(negedge CLK);
    Continue = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (st[0] == 3'd2) begin found = 1'b1; break; end
    end
    check("reached S33", 16'(found), 16'd1);
    @(negedge CLK);
    check("second S33 cycle", 16'(st[0]), 16'd2);
    Reset = 1'b1;
    @(negedge CLK);
    check("mid-wait reset state", 16'(st[0]), 16'd0);
    check("mid-wait reset Mem_OE", 16'(ctl[0][0]), 16'd0);
    check("mid-wait reset count", fc[0], 16'd0);
    check("mid-wait reset count mw1", fc[1], 16'd0);
    Reset = 1'b0;

    // Run dropped mid-fetch does not abort the fetch.
    Run = 1'b1;
    repeat (3) @(negedge CLK);
    Run = 1'b0;
    repeat (8) @(negedge CLK);
    check("fetch completes after Run drop", 16'(st[0]), 16'd4);
    check("count after Run drop", fc[0], 16'd1);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
